// File: rtl/csr_trap_unit_pkg.sv
// Shared CSR addresses, cause codes and field positions for the machine-mode CSR/trap block.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int CAUSE_MSI = 3;
    localparam int CAUSE_MTI = 7;
    localparam int CAUSE_MEI = 11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    // Reserved mtvec modes 2/3 collapse to direct mode.
    function automatic logic [31:0] legalize_mtvec(input logic [31:0] value);
        return (value[1:0] == MTVEC_VECTORED) ? value : {value[31:2], MTVEC_DIRECT};
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit CSR counter; a write to either half replaces it and holds off the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wr_data;
            if (wr_hi) count[63:32] <= wr_data;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: commits trap/MRET state, serves CSR reads,
// synchronises interrupt lines and produces fetch redirect targets.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'd0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] read_addr,
    output logic [31:0] read_data,
    input  logic        write_enable,
    input  logic [11:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        retired,
    input  logic        traped,
    input  logic [3:0]  ecause,
    input  logic        interupt,
    input  logic [31:0] ecp,
    input  logic        mret,
    input  logic        sw_irq,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic        sip,
    output logic        tip,
    output logic        eip,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_vector
);

    logic [SYNC_STAGES-1:0] sw_sync, tmr_sync, ext_sync;
    logic        msip, mtip, meip;
    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip;
    logic [31:0] trap_base;
    logic [63:0] mcycle, minstret;
    logic        csr_wr;
    logic        unused_ecp_bits;

    assign unused_ecp_bits = ^ecp[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_sync  <= '0;
            tmr_sync <= '0;
            ext_sync <= '0;
        end else begin
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_irq};
            tmr_sync <= {tmr_sync[SYNC_STAGES-2:0], timer_irq};
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
        end
    end

    assign msip = sw_sync[SYNC_STAGES-1];
    assign mtip = tmr_sync[SYNC_STAGES-1];
    assign meip = ext_sync[SYNC_STAGES-1];
    assign mip  = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};

    // A trapping instruction is squashed, so its CSR write never lands.
    assign csr_wr = write_enable & ~traped;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= RESET_MTVEC;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else if (traped) begin
            mepc_q       <= {ecp[31:2], 2'b00};
            mcause_q     <= {interupt, 27'b0, ecause};
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else begin
            if (write_enable) begin
                case (write_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= write_data[MSTATUS_MIE];
                        mstatus_mpie <= write_data[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= write_data & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= legalize_mtvec(write_data);
                    CSR_MSCRATCH: mscratch_q <= write_data;
                    CSR_MEPC:     mepc_q     <= {write_data[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= write_data;
                    default: ;
                endcase
            end
            // Placed after the write so MRET wins the MIE/MPIE fields.
            if (mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (1'b1),
        .wr_lo   (csr_wr && write_addr == CSR_MCYCLE),
        .wr_hi   (csr_wr && write_addr == CSR_MCYCLEH),
        .wr_data (write_data),
        .count   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (retired & ~traped),
        .wr_lo   (csr_wr && write_addr == CSR_MINSTRET),
        .wr_hi   (csr_wr && write_addr == CSR_MINSTRETH),
        .wr_data (write_data),
        .count   (minstret)
    );

    always_comb begin
        read_data = '0;
        case (read_addr)
            CSR_MSTATUS: begin
                read_data[MSTATUS_MIE]  = mstatus_mie;
                read_data[MSTATUS_MPIE] = mstatus_mpie;
            end
            CSR_MISA:                    read_data = MISA_VALUE;
            CSR_MIE:                     read_data = mie_q;
            CSR_MTVEC:                   read_data = mtvec_q;
            CSR_MSCRATCH:                read_data = mscratch_q;
            CSR_MEPC:                    read_data = mepc_q;
            CSR_MCAUSE:                  read_data = mcause_q;
            CSR_MIP:                     read_data = mip;
            CSR_MCYCLE,   CSR_CYCLE:     read_data = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    read_data = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   read_data = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: read_data = minstret[63:32];
            CSR_MHARTID:                 read_data = MHARTID;
            default: ;
        endcase
    end

    assign sip = mstatus_mie & mie_q[CAUSE_MSI] & msip;
    assign tip = mstatus_mie & mie_q[CAUSE_MTI] & mtip;
    assign eip = mstatus_mie & mie_q[CAUSE_MEI] & meip;

    assign trap_base   = {mtvec_q[31:2], 2'b00};
    assign trap_vector = (mtvec_q[1:0] == MTVEC_VECTORED && interupt)
                       ? trap_base + {26'b0, ecause, 2'b00}
                       : trap_base;
    assign mret_vector = mepc_q;

endmodule
